// File: rtl/ir_tx_pkg.sv
// Shared types, default timing and helpers for the IR frame transmitter.
// Timing values are in microseconds and converted to cycles at elaboration.
package ir_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEAD_M,
    ST_LEAD_S,
    ST_SEG0,
    ST_LINK_M,
    ST_LINK_S,
    ST_SEG1,
    ST_STOP_M,
    ST_RPT_GAP
  } ir_state_e;

  localparam int DEF_CLK_HZ        = 125_000_000;
  localparam int DEF_CARRIER_HZ    = 38_000;
  localparam int DEF_MAX_BITS      = 64;
  localparam int DEF_SEG0_BITS     = 35;
  localparam int DEF_SEG1_BITS     = 32;
  localparam int DEF_LEAD_MARK_US  = 9000;
  localparam int DEF_LEAD_SPACE_US = 4500;
  localparam int DEF_BIT_MARK_US   = 750;
  localparam int DEF_ZERO_SPACE_US = 450;
  localparam int DEF_ONE_SPACE_US  = 1500;
  localparam int DEF_LINK_SPACE_US = 20000;
  localparam int DEF_RPT_GAP_US    = 40000;

  function automatic int us_to_cycles(
    input int clk_hz,
    input int us
  );
    return (clk_hz / 1_000_000) * us;
  endfunction

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_mark_space_timer.sv
// One mark-then-space phase timer; restarted by load on every phase change.
// mark is high for the first mark_cycles cycles, last flags the final cycle.
module ir_mark_space_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] mark_cycles,
  input  logic [W-1:0] space_cycles,
  output logic         mark,
  output logic         last
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] total;

  assign total = mark_cycles + space_cycles;
  assign cnt_d = load ? '0 : cnt_q + ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mark = (cnt_q < mark_cycles);
  assign last = ((cnt_q + ONE) == total);

endmodule

// File: rtl/ir_frame_tx.sv
// IR remote frame transmitter: lead, SEG0, link, SEG1, stop, optional
// repeats with gaps; emits the envelope and the carrier-gated LED drive.
module ir_frame_tx
  import ir_tx_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int CARRIER_HZ    = DEF_CARRIER_HZ,
  parameter int MAX_BITS      = DEF_MAX_BITS,
  parameter int SEG0_BITS     = DEF_SEG0_BITS,
  parameter int SEG1_BITS     = DEF_SEG1_BITS,
  parameter int LEAD_MARK_US  = DEF_LEAD_MARK_US,
  parameter int LEAD_SPACE_US = DEF_LEAD_SPACE_US,
  parameter int BIT_MARK_US   = DEF_BIT_MARK_US,
  parameter int ZERO_SPACE_US = DEF_ZERO_SPACE_US,
  parameter int ONE_SPACE_US  = DEF_ONE_SPACE_US,
  parameter int LINK_SPACE_US = DEF_LINK_SPACE_US,
  parameter int RPT_GAP_US    = DEF_RPT_GAP_US
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [MAX_BITS-1:0] seg0_data,
  input  logic [MAX_BITS-1:0] seg1_data,
  input  logic [3:0]          repeat_cnt,
  output logic                busy,
  output logic                done,
  output logic                ir_env_n,
  output logic                ir_mod
);

  localparam int T_LM   = us_to_cycles(CLK_HZ, LEAD_MARK_US);
  localparam int T_LS   = us_to_cycles(CLK_HZ, LEAD_SPACE_US);
  localparam int T_BM   = us_to_cycles(CLK_HZ, BIT_MARK_US);
  localparam int T_ZERO = us_to_cycles(CLK_HZ, ZERO_SPACE_US);
  localparam int T_ONE  = us_to_cycles(CLK_HZ, ONE_SPACE_US);
  localparam int T_LINK = us_to_cycles(CLK_HZ, LINK_SPACE_US);
  localparam int T_GAP  = us_to_cycles(CLK_HZ, RPT_GAP_US);

  localparam int MAXT = max2(
    max2(max2(T_LM, T_LS), max2(T_BM + T_ONE, T_BM + T_ZERO)),
    max2(T_LINK, T_GAP));
  localparam int TW  = $clog2(MAXT) + 1;
  localparam int IW  = $clog2(MAX_BITS + 1);
  localparam int PER = CLK_HZ / CARRIER_HZ;
  localparam int CW  = (PER > 1) ? $clog2(PER) : 1;

  localparam logic [TW-1:0] C_LM   = TW'(T_LM);
  localparam logic [TW-1:0] C_LS   = TW'(T_LS);
  localparam logic [TW-1:0] C_BM   = TW'(T_BM);
  localparam logic [TW-1:0] C_ZERO = TW'(T_ZERO);
  localparam logic [TW-1:0] C_ONE  = TW'(T_ONE);
  localparam logic [TW-1:0] C_LINK = TW'(T_LINK);
  localparam logic [TW-1:0] C_GAP  = TW'(T_GAP);

  localparam logic [IW-1:0] IDX0  = IW'(SEG0_BITS - 1);
  localparam logic [IW-1:0] IDX1  = IW'((SEG1_BITS > 0) ? SEG1_BITS - 1 : 0);
  localparam logic [IW-1:0] I_ONE = IW'(1);

  localparam logic [CW-1:0] PER_M1 = CW'(PER - 1);
  localparam logic [CW-1:0] HALF   = CW'(PER / 2);
  localparam logic [CW-1:0] CA_ONE = CW'(1);

  localparam logic [MAX_BITS-1:0] LSB1 = MAX_BITS'(1);

  if (SEG0_BITS < 1 || SEG0_BITS > MAX_BITS ||
      SEG1_BITS < 0 || SEG1_BITS > MAX_BITS) begin : g_bad_cfg
    $error("ir_frame_tx: SEG0_BITS/SEG1_BITS out of range");
  end

  ir_state_e           state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          rpt_q, rpt_d;
  logic [MAX_BITS-1:0] seg0_q, seg0_d;
  logic [MAX_BITS-1:0] seg1_q, seg1_d;
  logic                done_q, done_d;
  logic [CW-1:0]       car_q, car_d;

  logic                load;
  logic [TW-1:0]       mark_c;
  logic [TW-1:0]       space_c;
  logic                tmr_mark;
  logic                tmr_last;
  logic                accept;
  logic [MAX_BITS-1:0] cur_seg;
  logic                cur_bit;
  logic [TW-1:0]       bit_space;

  ir_mark_space_timer #(
    .W(TW)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .mark_cycles (mark_c),
    .space_cycles(space_c),
    .mark        (tmr_mark),
    .last        (tmr_last)
  );

  assign frame_ready = (state_q == ST_IDLE);
  assign busy        = ~frame_ready;
  assign accept      = frame_valid & frame_ready;
  assign done        = done_q;

  assign cur_seg   = (state_q == ST_SEG1) ? seg1_q : seg0_q;
  assign cur_bit   = |(cur_seg & (LSB1 << idx_q));
  assign bit_space = cur_bit ? C_ONE : C_ZERO;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rpt_d   = rpt_q;
    seg0_d  = seg0_q;
    seg1_d  = seg1_q;
    done_d  = 1'b0;
    load    = 1'b0;
    mark_c  = '0;
    space_c = '0;
    unique case (state_q)
      ST_IDLE: begin
        load = 1'b1;
        if (frame_valid) begin
          state_d = ST_LEAD_M;
          seg0_d  = seg0_data;
          seg1_d  = seg1_data;
          rpt_d   = repeat_cnt;
        end
      end
      ST_LEAD_M: begin
        mark_c = C_LM;
        if (tmr_last) begin
          state_d = ST_LEAD_S;
          load    = 1'b1;
        end
      end
      ST_LEAD_S: begin
        space_c = C_LS;
        if (tmr_last) begin
          state_d = ST_SEG0;
          idx_d   = IDX0;
          load    = 1'b1;
        end
      end
      ST_SEG0: begin
        mark_c  = C_BM;
        space_c = bit_space;
        if (tmr_last) begin
          load = 1'b1;
          if (idx_q == '0) begin
            state_d = (SEG1_BITS == 0) ? ST_STOP_M : ST_LINK_M;
          end else begin
            idx_d = idx_q - I_ONE;
          end
        end
      end
      ST_LINK_M: begin
        mark_c = C_BM;
        if (tmr_last) begin
          state_d = ST_LINK_S;
          load    = 1'b1;
        end
      end
      ST_LINK_S: begin
        space_c = C_LINK;
        if (tmr_last) begin
          state_d = ST_SEG1;
          idx_d   = IDX1;
          load    = 1'b1;
        end
      end
      ST_SEG1: begin
        mark_c  = C_BM;
        space_c = bit_space;
        if (tmr_last) begin
          load = 1'b1;
          if (idx_q == '0) begin
            state_d = ST_STOP_M;
          end else begin
            idx_d = idx_q - I_ONE;
          end
        end
      end
      ST_STOP_M: begin
        mark_c = C_BM;
        if (tmr_last) begin
          load = 1'b1;
          if (rpt_q != 4'd0) begin
            rpt_d   = rpt_q - 4'd1;
            state_d = ST_RPT_GAP;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RPT_GAP: begin
        space_c = C_GAP;
        if (tmr_last) begin
          state_d = ST_LEAD_M;
          load    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        load    = 1'b1;
      end
    endcase
  end

  // Carrier phase restarts at acceptance so every frame opens on a high half.
  always_comb begin
    car_d = car_q;
    if (accept) begin
      car_d = '0;
    end else if (busy) begin
      car_d = (car_q == PER_M1) ? '0 : car_q + CA_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rpt_q   <= '0;
      seg0_q  <= '0;
      seg1_q  <= '0;
      done_q  <= 1'b0;
      car_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rpt_q   <= rpt_d;
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
      done_q  <= done_d;
      car_q   <= car_d;
    end
  end

  assign ir_env_n = ~(busy & tmr_mark);
  assign ir_mod   = ~ir_env_n & (car_q < HALF);

endmodule

// File: tb/tb_ir_frame_tx.sv
// Directed bench for ir_frame_tx with a per-cycle envelope/carrier model.
// Timing is scaled to 1 cycle = 1 us with shortened phases to bound run time.
module tb_ir_frame_tx;

  localparam int PER  = 10;
  localparam int LM   = 900;
  localparam int LS   = 450;
  localparam int BM   = 75;
  localparam int ZERO = 45;
  localparam int ONE  = 150;
  localparam int LINK = 2000;
  localparam int GAP  = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_valid;
  logic       frame_ready;
  logic [7:0] seg0_data;
  logic [7:0] seg1_data;
  logic [3:0] repeat_cnt;
  logic       busy;
  logic       done;
  logic       ir_env_n;
  logic       ir_mod;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int last_len = 0;
  int last_marks = 0;
  int k = 0;
  bit exp_q[$];
  bit idle_now = 1'b1;
  bit done_pend = 1'b0;
  bit e;
  logic [4:0] ev;
  logic [4:0] av;

  always #5 clk = ~clk;

  ir_frame_tx #(
    .CLK_HZ       (1_000_000),
    .CARRIER_HZ   (100_000),
    .MAX_BITS     (8),
    .SEG0_BITS    (4),
    .SEG1_BITS    (3),
    .LEAD_MARK_US (LM),
    .LEAD_SPACE_US(LS),
    .BIT_MARK_US  (BM),
    .ZERO_SPACE_US(ZERO),
    .ONE_SPACE_US (ONE),
    .LINK_SPACE_US(LINK),
    .RPT_GAP_US   (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .seg0_data  (seg0_data),
    .seg1_data  (seg1_data),
    .repeat_cnt (repeat_cnt),
    .busy       (busy),
    .done       (done),
    .ir_env_n   (ir_env_n),
    .ir_mod     (ir_mod)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Envelope as a list of (mark, space) runs, 0 = mark.
  function automatic void push_run(input int m, input int s);
    for (int i = 0; i < m; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < s; i++) exp_q.push_back(1'b1);
    last_len += m + s;
    if (m > 0) last_marks++;
  endfunction

  function automatic void build(input logic [3:0] s0, input logic [2:0] s1,
                                input int rpt);
    last_len   = 0;
    last_marks = 0;
    for (int r = 0; r <= rpt; r++) begin
      push_run(LM, LS);
      for (int b = 3; b >= 0; b--) push_run(BM, s0[b] ? ONE : ZERO);
      push_run(BM, LINK);
      for (int b = 2; b >= 0; b--) push_run(BM, s1[b] ? ONE : ZERO);
      push_run(BM, 0);
      if (r < rpt) push_run(0, GAP);
    end
  endfunction

  always @(posedge clk or negedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      idle_now  = 1'b1;
      done_pend = 1'b0;
      k         = 0;
    end else if (clk) begin
      if (idle_now && frame_valid) begin
        build(seg0_data[3:0], seg1_data[2:0], int'(repeat_cnt));
        k = 0;
      end
    end
    if (!clk) begin
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ev = {1'b1, 1'b0, 1'b0, e, (!e && ((k % PER) < PER / 2))};
        k++;
        idle_now = 1'b0;
        if (exp_q.size() == 0) done_pend = 1'b1;
      end else begin
        ev = {1'b0, 1'b1, done_pend, 1'b1, 1'b0};
        done_pend = 1'b0;
        idle_now  = 1'b1;
      end
      av = {busy, frame_ready, done, ir_env_n, ir_mod};
      n_cmp++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL cycle {busy,rdy,done,env_n,mod}: got %b expected %b at %0t",
                 av, ev, $time);
      end
      if (rst && done) done_cnt++;
      if (rst && busy) busy_cnt++;
    end
  end

  task automatic send(input logic [3:0] s0, input logic [2:0] s1,
                      input logic [3:0] r);
    @(posedge clk);
    #1;
    frame_valid = 1'b1;
    seg0_data   = {4'b0110, s0};
    seg1_data   = {5'b10101, s1};
    repeat_cnt  = r;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    chk("first_mark_latency", {ir_env_n, busy}, 2'b01);
  endtask

  task automatic wait_done(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_within_budget", seen, 1);
  endtask

  int b0;
  int d0;
  logic [19:0] pat;

  initial begin
    pat         = 20'b00000111110000011111;
    rst         = 1'b0;
    frame_valid = 1'b0;
    seg0_data   = '0;
    seg1_data   = '0;
    repeat_cnt  = '0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      frame_valid = ~frame_valid;
      seg0_data   = 8'($urandom);
      seg1_data   = 8'($urandom);
      repeat_cnt  = 4'($urandom);
      @(negedge clk);
      chk("reset_outputs", {frame_ready, busy, done, ir_env_n, ir_mod},
          5'b10010);
    end
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    rst         = 1'b1;

    b0 = busy_cnt;
    d0 = done_cnt;
    send(4'b1010, 3'b011, 4'd0);
    wait_done(6000);
    @(posedge clk);
    #1;
    chk("one_frame_busy_cycles", busy_cnt - b0, 4760);
    chk("one_frame_done_pulses", done_cnt - d0, 1);
    chk("one_frame_model_len", last_len, 4760);
    chk("one_frame_model_marks", last_marks, 10);

    b0 = busy_cnt;
    d0 = done_cnt;
    send(4'b1010, 3'b011, 4'd2);
    repeat (1500) @(posedge clk);
    #1;
    frame_valid = 1'b1;
    seg0_data   = 8'hFF;
    seg1_data   = 8'hFF;
    repeat_cnt  = 4'd5;
    repeat (20) @(negedge clk);
    chk("busy_ready_low", frame_ready, 0);
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    wait_done(16000);
    @(posedge clk);
    #1;
    chk("repeat_busy_cycles", busy_cnt - b0, 14480);
    chk("repeat_done_pulses", done_cnt - d0, 1);
    chk("repeat_model_len", last_len, 14480);
    chk("repeat_model_marks", last_marks, 30);
    repeat (50) @(negedge clk);
    chk("no_second_frame", busy, 0);
    chk("no_extra_done", done_cnt - d0, 1);

    send(4'b1010, 3'b011, 4'd0);
    repeat (4200) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_outputs", {ir_env_n, ir_mod, busy, frame_ready, done},
        5'b10010);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("abort_no_done", done_cnt - d0, 0);
    b0 = busy_cnt;
    send(4'b1010, 3'b011, 4'd0);
    wait_done(6000);
    @(posedge clk);
    #1;
    chk("post_abort_busy_cycles", busy_cnt - b0, 4760);
    chk("post_abort_done_pulses", done_cnt - d0, 1);

    b0 = busy_cnt;
    d0 = done_cnt;
    frame_valid = 1'b1;
    seg0_data   = 8'h6A;
    seg1_data   = 8'hAB;
    repeat_cnt  = 4'd0;
    @(posedge clk);
    #1;
    chk("b2b_first_start", {ir_env_n, busy}, 2'b01);
    wait_done(6000);
    chk("b2b_ready_on_done", {frame_ready, done}, 2'b11);
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    chk("b2b_second_start", {ir_env_n, busy}, 2'b01);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("lead_carrier", ir_mod, pat[i]);
    end
    wait_done(6000);
    @(posedge clk);
    #1;
    chk("b2b_busy_cycles", busy_cnt - b0, 9520);
    chk("b2b_done_pulses", done_cnt - d0, 2);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
